time_count_alarm: RTL and testbench

TIME_COUNT_ALARM -- requirements
Module: time_count_alarm

---
 rtl/clock_pkg.sv | 31 +++
 rtl/key_edge.sv | 37 +++
 rtl/time_count_alarm.sv | 164 ++++++++++++++++
 tb/tb_time_count_alarm.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Purpose  : Shared limits, ring-state encoding and BCD wrap-increment helper
//            for the time/alarm counter.
// Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam logic [7:0] MAX_HOUR_BCD = 8'h23;
    localparam logic [7:0] MAX_MIN_BCD  = 8'h59;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RING = 1'b1;

    // Packed-BCD increment; returns 00 once the value has reached max.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] val,
                                                input logic [7:0] max);
        logic [7:0] res;
        if (val == max) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
// Module   : key_edge
// Purpose  : Synchronizes an asynchronous adjust level and emits a registered
//            one-clk pulse on its rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module key_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;

    // Pulse is registered so an edge sampled at N acts at N+SYNC_STAGES+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_level};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/time_count_alarm.sv
`default_nettype none
// ============================================================================
// Module   : time_count_alarm
// Purpose  : BCD time-of-day counter with adjustable alarm and timed ringer.
// Revision : 1.0 - initial release
// ============================================================================
module time_count_alarm
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RING_SECS   = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       count1,
    input  logic       counta,
    input  logic       count2,
    input  logic       countb,
    input  logic       alarm_en,
    output logic [7:0] time_hh,
    output logic [7:0] time_mm,
    output logic [7:0] time_ss,
    output logic [7:0] alarm_hh,
    output logic [7:0] alarm_mm,
    output logic       alarm_ring
);

    localparam logic [7:0] c_RING_LAST = 8'(RING_SECS - 1);

    logic [3:0] w_levels;
    logic [3:0] w_pulses;
    logic       w_p1, w_pa, w_p2, w_pb;
    logic       w_time_adj, w_any_adj;

    logic [7:0] r_hh, r_mm, r_ss, r_ahh, r_amm;
    logic [7:0] w_hh_nxt, w_mm_nxt, w_ss_nxt;
    logic       w_sec_wrap;

    logic [0:0] r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_alarm_ring;

    assign w_levels = {countb, count2, counta, count1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            key_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_key (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_level(w_levels[gi]),
                .o_pulse(w_pulses[gi])
            );
        end
    endgenerate

    assign w_p1       = w_pulses[0];
    assign w_pa       = w_pulses[1];
    assign w_p2       = w_pulses[2];
    assign w_pb       = w_pulses[3];
    assign w_time_adj = w_p1 | w_pa;
    assign w_any_adj  = w_time_adj | w_p2 | w_pb;

    // A time adjust swallows a coincident tick.
    always_comb begin
        w_hh_nxt   = r_hh;
        w_mm_nxt   = r_mm;
        w_ss_nxt   = r_ss;
        w_sec_wrap = 1'b0;
        if (w_time_adj) begin
            if (w_p1) begin
                w_mm_nxt = bcd_inc_wrap(r_mm, MAX_MIN_BCD);
                w_ss_nxt = 8'h00;
            end
            if (w_pa) begin
                w_hh_nxt = bcd_inc_wrap(r_hh, MAX_HOUR_BCD);
            end
        end else if (tick_1hz) begin
            w_ss_nxt = bcd_inc_wrap(r_ss, MAX_MIN_BCD);
            if (r_ss == MAX_MIN_BCD) begin
                w_sec_wrap = 1'b1;
                w_mm_nxt   = bcd_inc_wrap(r_mm, MAX_MIN_BCD);
                if (r_mm == MAX_MIN_BCD) begin
                    w_hh_nxt = bcd_inc_wrap(r_hh, MAX_HOUR_BCD);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hh  <= 8'h00;
            r_mm  <= 8'h00;
            r_ss  <= 8'h00;
            r_ahh <= 8'h00;
            r_amm <= 8'h00;
        end else begin
            r_hh <= w_hh_nxt;
            r_mm <= w_mm_nxt;
            r_ss <= w_ss_nxt;
            if (w_p2) begin
                r_amm <= bcd_inc_wrap(r_amm, MAX_MIN_BCD);
            end
            if (w_pb) begin
                r_ahh <= bcd_inc_wrap(r_ahh, MAX_HOUR_BCD);
            end
        end
    end

    // Ringing starts only from a natural minute rollover, never from an adjust.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_sec_wrap && !w_any_adj && alarm_en &&
                    (w_hh_nxt == r_ahh) && (w_mm_nxt == r_amm)) begin
                    w_state_nxt = ST_RING;
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_RING: begin
                if (!alarm_en || w_any_adj) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (tick_1hz) begin
                    if (r_cnt == c_RING_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_alarm_ring <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_alarm_ring <= (w_state_nxt == ST_RING);
        end
    end

    assign time_hh    = r_hh;
    assign time_mm    = r_mm;
    assign time_ss    = r_ss;
    assign alarm_hh   = r_ahh;
    assign alarm_mm   = r_amm;
    assign alarm_ring = r_alarm_ring;

endmodule
`default_nettype wire

// File: tb/tb_time_count_alarm.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_count_alarm
// Purpose  : Self-checking bench for time_count_alarm against a seconds-of-day
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_count_alarm;

    localparam int S    = 2;
    localparam int RING = 60;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       count1   = 1'b0;
    logic       counta   = 1'b0;
    logic       count2   = 1'b0;
    logic       countb   = 1'b0;
    logic       alarm_en = 1'b0;
    logic       en_lvl   = 1'b0;
    logic [7:0] time_hh, time_mm, time_ss, alarm_hh, alarm_mm;
    logic       alarm_ring;
    logic [40:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model: time as seconds of day, alarm as minute of day.
    int          m_secs, m_amin, m_rcnt;
    bit          m_ring;
    logic [15:0] h1, ha, h2, hb;

    time_count_alarm #(.SYNC_STAGES(S), .RING_SECS(RING)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .count1    (count1),
        .counta    (counta),
        .count2    (count2),
        .countb    (countb),
        .alarm_en  (alarm_en),
        .time_hh   (time_hh),
        .time_mm   (time_mm),
        .time_ss   (time_ss),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm_ring(alarm_ring)
    );

    assign obs = {time_hh, time_mm, time_ss, alarm_hh, alarm_mm, alarm_ring};

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [40:0] exp_vec();
        return {bcd(m_secs / 3600), bcd((m_secs / 60) % 60), bcd(m_secs % 60),
                bcd(m_amin / 60), bcd(m_amin % 60), m_ring};
    endfunction

    task automatic model_clear();
        m_secs = 0; m_amin = 0; m_rcnt = 0; m_ring = 0;
        h1 = '0; ha = '0; h2 = '0; hb = '0;
    endtask

    // An input level first seen high at edge E-(S+1) takes effect at edge E.
    task automatic model_edge();
        bit p1, pa, p2, pb, tadj, anyadj, wrap;
        int h, m, s;
        h1 = {h1[14:0], count1};
        ha = {ha[14:0], counta};
        h2 = {h2[14:0], count2};
        hb = {hb[14:0], countb};
        p1 = h1[S+1] & ~h1[S+2];
        pa = ha[S+1] & ~ha[S+2];
        p2 = h2[S+1] & ~h2[S+2];
        pb = hb[S+1] & ~hb[S+2];
        tadj   = p1 | pa;
        anyadj = tadj | p2 | pb;
        wrap   = 0;
        h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
        if (tadj) begin
            if (p1) begin m = (m + 1) % 60; s = 0; end
            if (pa) h = (h + 1) % 24;
            m_secs = h * 3600 + m * 60 + s;
        end else if (tick_1hz) begin
            wrap   = (s == 59);
            m_secs = (m_secs + 1) % 86400;
        end
        if (!m_ring) begin
            if (wrap && !anyadj && alarm_en && (m_secs / 60 == m_amin)) begin
                m_ring = 1; m_rcnt = 0;
            end
        end else if (!alarm_en || anyadj) begin
            m_ring = 0;
        end else if (tick_1hz) begin
            m_rcnt++;
            if (m_rcnt == RING) m_ring = 0;
        end
        if (p2) m_amin = (m_amin / 60) * 60 + (m_amin % 60 + 1) % 60;
        if (pb) m_amin = ((m_amin / 60 + 1) % 24) * 60 + m_amin % 60;
    endtask

    task automatic step(input logic t, input logic c1, input logic ca,
                        input logic c2, input logic cb);
        @(negedge clk);
        tick_1hz = t; count1 = c1; counta = ca; count2 = c2; countb = cb;
        alarm_en = en_lvl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse(input int which);
        logic [3:0] v;
        v = 4'b0001 << which;
        step(1'b0, v[0], v[1], v[2], v[3]);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick_1hz = 0; count1 = 0; counta = 0; count2 = 0; countb = 0;
        en_lvl = 0; alarm_en = 0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        do_reset();
        repeat (h) pulse(1);
        repeat (m) pulse(0);
        idle(4);
        repeat (s) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_alarm(input int h, input int m);
        repeat (h) pulse(3);
        repeat (m) pulse(2);
        idle(4);
    endtask

    task automatic test_reset();
        model_clear();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 41'h0) begin
            errors++; $display("FAIL reset_state: got %h expected %h", obs, 41'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_idle: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_rollover();
        set_time(23, 59, 58);
        checks++;
        if (obs[40:17] !== 24'h235958) begin
            errors++; $display("FAIL setup_235958: got %h expected 235958", obs[40:17]);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs[40:17] !== 24'h235959 || obs !== exp_vec()) begin
            errors++; $display("FAIL tick_235959: got %h expected %h", obs, exp_vec());
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs[40:17] !== 24'h000000 || obs !== exp_vec()) begin
            errors++; $display("FAIL day_wrap: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_hold();
        set_time(10, 59, 30);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs[40:17] !== 24'h105930) begin
            errors++; $display("FAIL hold_before_n3: got %h expected 105930", obs[40:17]);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs[40:17] !== 24'h100000 || obs !== exp_vec()) begin
            errors++; $display("FAIL hold_at_n3: got %h expected %h", obs, exp_vec());
        end
        repeat (46) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        checks++;
        if (obs[40:17] !== 24'h100000 || obs !== exp_vec()) begin
            errors++; $display("FAIL hold_single_inc: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_coincide();
        set_time(9, 15, 20);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs[40:17] !== 24'h101520 || obs !== exp_vec()) begin
            errors++; $display("FAIL adj_vs_tick: got %h expected %h", obs, exp_vec());
        end
        // Both time adjusts together, plus an alarm adjust beside a tick.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs[40:17] !== 24'h111601 || obs[8:1] !== 8'h01 || obs !== exp_vec()) begin
            errors++; $display("FAIL dual_adj: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_alarm();
        set_time(7, 29, 59);
        set_alarm(7, 30);
        en_lvl = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== {24'h073000, 16'h0730, 1'b1} || obs !== exp_vec()) begin
            errors++; $display("FAIL ring_start: got %h expected %h", obs, exp_vec());
        end
        for (int i = 1; i <= 60; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec() || alarm_ring !== (i < 60)) begin
                errors++; $display("FAIL ring_tick%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (obs[40:17] !== 24'h073100) begin
            errors++; $display("FAIL ring_end_time: got %h expected 073100", obs[40:17]);
        end
        set_time(7, 29, 59);
        set_alarm(7, 30);
        en_lvl = 1'b1;
        repeat (11) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (alarm_ring !== 1'b1) begin
            errors++; $display("FAIL ring_before_adj: got %b expected 1", alarm_ring);
        end
        idle(1);
        checks++;
        if (alarm_ring !== 1'b0 || alarm_mm !== 8'h31 || obs !== exp_vec()) begin
            errors++; $display("FAIL ring_adj_stop: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [3:0] lv;
        set_time(6, 44, 50);
        set_alarm(6, 45);
        en_lvl = 1'b1;
        lv = '0;
        for (int i = 0; i < 1500; i++) begin
            if (i >= 100) begin
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 39) == 0) lv[k] = ~lv[k];
                end
                en_lvl = ($urandom_range(0, 249) != 0);
            end
            step(($urandom_range(0, 1) == 0), lv[0], lv[1], lv[2], lv[3]);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random_cyc%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_midring();
        set_time(12, 33, 59);
        set_alarm(12, 34);
        en_lvl = 1'b1;
        repeat (57) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== {24'h123456, 16'h1234, 1'b1} || obs !== exp_vec()) begin
            errors++; $display("FAIL midring_setup: got %h expected %h", obs, exp_vec());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 41'h0) begin
            errors++; $display("FAIL async_reset: got %h expected %h", obs, 41'h0);
        end
        model_clear();
        en_lvl = 1'b0;
        count1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        checks++;
        if (obs !== {24'h000100, 16'h0000, 1'b0} || obs !== exp_vec()) begin
            errors++; $display("FAIL held_at_release: got %h expected %h", obs, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_hold();
        test_coincide();
        test_alarm();
        test_random();
        test_reset_midring();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
